// File: rtl/pim_matrix_loader_if.sv
// Element stream into pim_matrix_loader: valid/ready handshake with an end-of-frame marker.
interface pim_matrix_loader_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/pim_matrix_loader.sv
// Assembles a streamed frame into row-major matrix_A/matrix_B, pulses start, then holds them until result_ready.
// Optional WAIT watchdog enabled by defining PIM_LOADER_TIMEOUT_EN.
module pim_matrix_loader #(
  parameter int WIDTH          = 32,
  parameter int MATRIX_SIZE    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                          clk,
  input  logic                                          rst,
  pim_matrix_loader_if.slave                            stream,
  output logic [MATRIX_SIZE*MATRIX_SIZE-1:0][WIDTH-1:0] matrix_A,
  output logic [MATRIX_SIZE*MATRIX_SIZE-1:0][WIDTH-1:0] matrix_B,
  output logic                                          start,
  input  logic                                          result_ready,
  output logic                                          busy,
  output logic                                          proto_err,
  output logic                                          timeout,
  output logic [15:0]                                   frame_count
);

  localparam int NN    = MATRIX_SIZE * MATRIX_SIZE;
  localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NN - 1);

  if (MATRIX_SIZE < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("pim_matrix_loader: MATRIX_SIZE must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {
    ST_LOAD_A = 2'd0,
    ST_LOAD_B = 2'd1,
    ST_START  = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  state_t                        state_r;
  state_t                        state_nxt_s;
  logic [IDX_W-1:0]              idx_r;
  logic [IDX_W-1:0]              idx_nxt_s;
  logic                          beat_s;
  logic                          load_state_s;
  logic                          wr_a_s;
  logic                          wr_b_s;
  logic                          proto_err_s;
  logic                          frame_inc_s;
  logic [NN-1:0][WIDTH-1:0]      matrix_a_r;
  logic [NN-1:0][WIDTH-1:0]      matrix_b_r;
  logic                          start_r;
  logic                          busy_r;
  logic                          proto_err_r;
  logic [15:0]                   frame_count_r;

`ifdef PIM_LOADER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wdog_r;
  logic [WD_W-1:0] wdog_nxt_s;
  logic            timeout_s;
  logic            timeout_r;
`endif

  // in_ready is gated by rst so it reads 0 throughout reset even though the reset state is LOAD_A.
  assign load_state_s    = (state_r == ST_LOAD_A) || (state_r == ST_LOAD_B);
  assign stream.in_ready = rst & load_state_s;
  assign beat_s          = stream.in_valid & stream.in_ready;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_LOAD_A;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, index and event decode.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    wr_a_s      = 1'b0;
    wr_b_s      = 1'b0;
    proto_err_s = 1'b0;
    frame_inc_s = 1'b0;
`ifdef PIM_LOADER_TIMEOUT_EN
    wdog_nxt_s  = wdog_r;
    timeout_s   = 1'b0;
`endif
    case (state_r)
      ST_LOAD_A: begin
        if (beat_s) begin
          wr_a_s = 1'b1;
          if (stream.in_last) begin
            proto_err_s = 1'b1;
            idx_nxt_s   = IDX_W'(0);
            state_nxt_s = ST_LOAD_A;
          end else if (idx_r == IDX_LAST) begin
            idx_nxt_s   = IDX_W'(0);
            state_nxt_s = ST_LOAD_B;
          end else begin
            idx_nxt_s = idx_r + IDX_W'(1);
          end
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      ST_LOAD_B: begin
        if (beat_s) begin
          wr_b_s = 1'b1;
          if (idx_r == IDX_LAST) begin
            // A missing marker on the final beat is flagged but the frame is still complete.
            proto_err_s = ~stream.in_last;
            idx_nxt_s   = IDX_W'(0);
            state_nxt_s = ST_START;
          end else if (stream.in_last) begin
            proto_err_s = 1'b1;
            idx_nxt_s   = IDX_W'(0);
            state_nxt_s = ST_LOAD_A;
          end else begin
            idx_nxt_s = idx_r + IDX_W'(1);
          end
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      ST_START: begin
        state_nxt_s = ST_WAIT;
`ifdef PIM_LOADER_TIMEOUT_EN
        wdog_nxt_s  = WD_W'(0);
`endif
      end
      ST_WAIT: begin
        if (result_ready) begin
          frame_inc_s = 1'b1;
          state_nxt_s = ST_LOAD_A;
        end else begin
`ifdef PIM_LOADER_TIMEOUT_EN
          if (wdog_r == WD_LAST) begin
            timeout_s   = 1'b1;
            state_nxt_s = ST_LOAD_A;
          end else begin
            wdog_nxt_s = wdog_r + WD_W'(1);
          end
`else
          state_nxt_s = ST_WAIT;
`endif
        end
      end
      default: begin
        state_nxt_s = ST_LOAD_A;
        idx_nxt_s   = IDX_W'(0);
      end
    endcase
  end

  // Element index and frame counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_r         <= IDX_W'(0);
      frame_count_r <= 16'd0;
    end else begin
      idx_r <= idx_nxt_s;
      if (frame_inc_s) begin
        frame_count_r <= frame_count_r + 16'd1;
      end
    end
  end

  // Matrix storage; only written during the two load states so it is frozen through START/WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      matrix_a_r <= '0;
      matrix_b_r <= '0;
    end else begin
      if (wr_a_s) begin
        matrix_a_r[idx_r] <= stream.in_data;
      end
      if (wr_b_s) begin
        matrix_b_r[idx_r] <= stream.in_data;
      end
    end
  end

  // Registered status outputs, aligned with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_r     <= 1'b0;
      busy_r      <= 1'b0;
      proto_err_r <= 1'b0;
    end else begin
      start_r     <= (state_nxt_s == ST_START);
      busy_r      <= (state_nxt_s == ST_START) || (state_nxt_s == ST_WAIT);
      proto_err_r <= proto_err_s;
    end
  end

`ifdef PIM_LOADER_TIMEOUT_EN
  // WAIT watchdog counter and its expiry pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_r    <= WD_W'(0);
      timeout_r <= 1'b0;
    end else begin
      wdog_r    <= wdog_nxt_s;
      timeout_r <= timeout_s;
    end
  end

  assign timeout = timeout_r;
`else
  assign timeout = 1'b0;
`endif

  assign matrix_A    = matrix_a_r;
  assign matrix_B    = matrix_b_r;
  assign start       = start_r;
  assign busy        = busy_r;
  assign proto_err   = proto_err_r;
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_pim_matrix_loader.sv
// Directed bench for pim_matrix_loader: table of full frames plus abort, reset and watchdog sequences.
module tb_pim_matrix_loader;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int NN = N * N;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 result_ready = 1'b0;
  logic [NN-1:0][W-1:0] matrix_A;
  logic [NN-1:0][W-1:0] matrix_B;
  logic                 start;
  logic                 busy;
  logic                 proto_err;
  logic                 timeout;
  logic [15:0]          frame_count;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int proto_cnt = 0;

  always #5 clk = ~clk;

  pim_matrix_loader_if #(.WIDTH(W)) bus ();

  pim_matrix_loader #(
    .WIDTH(W),
    .MATRIX_SIZE(N),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stream(bus),
    .matrix_A(matrix_A),
    .matrix_B(matrix_B),
    .start(start),
    .result_ready(result_ready),
    .busy(busy),
    .proto_err(proto_err),
    .timeout(timeout),
    .frame_count(frame_count)
  );

  // Pulse counters sampled on the falling edge.
  always @(negedge clk) begin
    if (start === 1'b1) start_cnt <= start_cnt + 1;
    if (proto_err === 1'b1) proto_cnt <= proto_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l, input bit stall);
    int n;
    int idle;
    idle = stall ? int'($urandom_range(0, 1)) : 0;
    bus.in_valid = 1'b0;
    repeat (idle) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (bus.in_ready !== 1'b1) chk("beat_accept_wait", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic chk_arrays(input string tag, input logic [31:0] base_a, input logic [31:0] base_b);
    for (int k = 0; k < NN; k++) begin
      chk($sformatf("%s_A[%0d]", tag, k), matrix_A[k], base_a + 32'(k));
      chk($sformatf("%s_B[%0d]", tag, k), matrix_B[k], base_b + 32'(k));
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < NN; k++) begin
      chk($sformatf("%s_A[%0d]", tag, k), matrix_A[k], 32'd0);
      chk($sformatf("%s_B[%0d]", tag, k), matrix_B[k], 32'd0);
    end
  endtask

  typedef struct {
    logic [31:0] base;
    bit          stall;
    bit          final_last;
    int          rr_cycles;
    int          exp_proto;
    logic [15:0] exp_frames;
  } row_t;

  row_t rows [4];

  initial begin
    int s0;
    int p0;
    int n;

    rows[0] = '{32'd1,          1'b0, 1'b1, 3, 0, 16'd1};
    rows[1] = '{32'd100,        1'b1, 1'b1, 1, 0, 16'd2};
    rows[2] = '{32'hFFFF_FFF0,  1'b0, 1'b1, 2, 0, 16'd3};
    rows[3] = '{32'd500,        1'b1, 1'b0, 1, 1, 16'd4};

    bus.in_valid = 1'b0;
    bus.in_data  = 32'd0;
    bus.in_last  = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
    chk_zero("rst");
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Table of complete frames
    for (int r = 0; r < 4; r++) begin
      s0 = start_cnt;
      p0 = proto_cnt;
      for (int k = 0; k < 2 * NN; k++) begin
        send_beat(rows[r].base + 32'(k), (k == 2 * NN - 1) ? rows[r].final_last : 1'b0, rows[r].stall);
      end
      chk($sformatf("row%0d_start_hi", r), {31'd0, start}, 32'd1);
      chk($sformatf("row%0d_busy_start", r), {31'd0, busy}, 32'd1);
      chk($sformatf("row%0d_in_ready_start", r), {31'd0, bus.in_ready}, 32'd0);
      chk($sformatf("row%0d_proto_final", r), {31'd0, proto_err}, 32'(rows[r].exp_proto));
      tick();
      chk($sformatf("row%0d_start_lo", r), {31'd0, start}, 32'd0);
      chk($sformatf("row%0d_busy_wait", r), {31'd0, busy}, 32'd1);
      chk_arrays($sformatf("row%0d", r), rows[r].base, rows[r].base + 32'(NN));
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hDEAD_BEEF;
      tick();
      tick();
      bus.in_valid = 1'b0;
      chk($sformatf("row%0d_wait_in_ready", r), {31'd0, bus.in_ready}, 32'd0);
      chk($sformatf("row%0d_wait_A0_stable", r), matrix_A[0], rows[r].base);
      chk($sformatf("row%0d_wait_B15_stable", r), matrix_B[NN-1], rows[r].base + 32'(2 * NN - 1));
      result_ready = 1'b1;
      repeat (rows[r].rr_cycles) tick();
      result_ready = 1'b0;
      chk($sformatf("row%0d_frame_count", r), {16'd0, frame_count}, {16'd0, rows[r].exp_frames});
      chk($sformatf("row%0d_in_ready_after", r), {31'd0, bus.in_ready}, 32'd1);
      chk($sformatf("row%0d_busy_after", r), {31'd0, busy}, 32'd0);
      chk($sformatf("row%0d_start_count", r), 32'(start_cnt - s0), 32'd1);
      chk($sformatf("row%0d_proto_count", r), 32'(proto_cnt - p0), 32'(rows[r].exp_proto));
    end

    // in_last on beat 10 aborts; following 32 beats form a frame with a missing final marker
    s0 = start_cnt;
    p0 = proto_cnt;
    for (int k = 0; k < 10; k++) send_beat(32'(k + 1), (k == 9), 1'b0);
    chk("abort_proto_hi", {31'd0, proto_err}, 32'd1);
    chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("abort_A9_written", matrix_A[9], 32'd10);
    tick();
    chk("abort_proto_lo", {31'd0, proto_err}, 32'd0);
    chk("abort_no_start", 32'(start_cnt - s0), 32'd0);
    for (int k = 0; k < 2 * NN; k++) send_beat(32'(k + 11), 1'b0, 1'b0);
    chk("nolast_start", {31'd0, start}, 32'd1);
    chk("nolast_proto", {31'd0, proto_err}, 32'd1);
    tick();
    chk_arrays("refill", 32'd11, 32'd27);
    chk("refill_start_count", 32'(start_cnt - s0), 32'd1);
    chk("refill_proto_count", 32'(proto_cnt - p0), 32'd2);

    // Reset while in WAIT
    #2;
    rst = 1'b0;
    #1;
    chk("rstwait_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rstwait_frame_count", {16'd0, frame_count}, 32'd0);
    chk("rstwait_busy", {31'd0, busy}, 32'd0);
    chk_zero("rstwait");
    tick();
    rst = 1'b1;
    tick();
    chk("rstwait_in_ready_after", {31'd0, bus.in_ready}, 32'd1);

    // Reset in the middle of LOAD_B
    s0 = start_cnt;
    for (int k = 0; k < NN + 5; k++) send_beat(32'(k + 200), 1'b0, 1'b0);
    chk("midb_busy", {31'd0, busy}, 32'd0);
    chk("midb_B4", matrix_B[4], 32'd220);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("rstmidb");
    chk("rstmidb_frame_count", {16'd0, frame_count}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("rstmidb_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
    repeat (4) tick();
    chk("rstmidb_no_start", 32'(start_cnt - s0), 32'd0);

`ifdef PIM_LOADER_TIMEOUT_EN
    // Watchdog: no result_ready after a complete frame
    for (int k = 0; k < 2 * NN; k++) send_beat(32'(k + 1), (k == 2 * NN - 1), 1'b0);
    n = 0;
    while (timeout !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("timeout_delay_from_start", 32'(n), 32'd17);
    chk("timeout_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("timeout_frame_count", {16'd0, frame_count}, 32'd0);
    tick();
    chk("timeout_pulse_lo", {31'd0, timeout}, 32'd0);
`else
    // Without the watchdog WAIT never exits on its own
    for (int k = 0; k < 2 * NN; k++) send_beat(32'(k + 1), (k == 2 * NN - 1), 1'b0);
    repeat (40) tick();
    chk("nowd_still_busy", {31'd0, busy}, 32'd1);
    chk("nowd_timeout_lo", {31'd0, timeout}, 32'd0);
    chk("nowd_in_ready", {31'd0, bus.in_ready}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pim_matrix_loader.md
Name: pim_matrix_loader

Overview:
- Upstream feeder for pim_controller.
- Accepts a valid/ready element stream and assembles it into the row-major matrix_A and matrix_B arrays.
- Pulses start once both matrices are complete, then holds the arrays stable until the controller returns result_ready.
- Sits between the host/DMA stream interface and pim_controller.

Parameters:
- WIDTH, 32, element width in bits.
- MATRIX_SIZE, 4, matrix dimension N; each matrix has N*N elements.
- TIMEOUT_CYCLES, 1024, WAIT watchdog limit (used only with PIM_LOADER_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  stream element valid.
- in_ready  out  1  loader can accept an element.
- in_data  in  WIDTH  stream element.
- in_last  in  1  marks the final element of a frame (element 2*N*N-1).
- matrix_A  out  WIDTH x N*N  assembled A, row-major, index i*N+j.
- matrix_B  out  WIDTH x N*N  assembled B, row-major.
- start  out  1  one-cycle pulse to pim_controller.
- result_ready  in  1  completion from pim_controller.
- busy  out  1  high in START and WAIT.
- proto_err  out  1  one-cycle pulse on an in_last mismatch.
- timeout  out  1  one-cycle pulse on watchdog expiry (tied 0 when the feature is off).
- frame_count  out  16  count of completed frames.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=LOAD_A, element counter=0.
  - All matrix_A and matrix_B entries = 0.
  - start=0, proto_err=0, timeout=0, frame_count=0.
  - in_ready=0 while reset is asserted; in_ready=1 in the first cycle after release.
- Handshake: a beat transfers when in_valid && in_ready at a rising clock edge. in_ready is a registered-state decode: 1 in LOAD_A/LOAD_B, 0 otherwise. It does not depend combinationally on in_valid.
- Counter idx, width clog2(N*N), resets to 0.
- LOAD_A: each beat writes matrix_A[idx] <= in_data and increments idx.
  - Beat with idx==N*N-1: idx <= 0, next state LOAD_B.
- LOAD_B: each beat writes matrix_B[idx].
  - Beat with idx==N*N-1: idx <= 0, next state START.
- START: start=1 for exactly this one cycle; next state WAIT.
- WAIT: no writes to either array, in_ready=0.
  - Any cycle with result_ready=1: frame_count <= frame_count+1 (wraps 0xFFFF->0), next state LOAD_A.
  - A result_ready held high for several cycles counts once, because the state leaves WAIT after the first cycle.
- result_ready outside WAIT is ignored.
- Start latency: start rises the cycle after the last B beat is accepted. With no stalls, a frame takes 2*N*N beat cycles plus 1 START cycle.
- Array stability: matrix outputs are stable from the cycle start is high until the state leaves WAIT. They change element by element during the next load, and the downstream block must not sample them then.
- in_last rules:
  - in_last on any beat other than the final B beat (last beat of LOAD_B): that beat is still written, proto_err pulses, idx <= 0, state <= LOAD_A (frame aborted, no start).
  - Final B beat without in_last: proto_err pulses, but the frame proceeds to START normally.
- Back-pressure: in_valid may drop at any time; the loader holds idx and state.
- Reset mid-operation (any state, including START/WAIT): immediate return to the reset values; any pending start is lost.

Optional Feature:
- Macro PIM_LOADER_TIMEOUT_EN.
- Defined:
  - Watchdog counter cleared on WAIT entry, incremented each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES-1 without result_ready: timeout pulses one cycle, state <= LOAD_A, frame_count unchanged.
  - result_ready in that same cycle has priority: normal completion, no timeout.
- Not defined: no watchdog logic, timeout tied 0, WAIT waits indefinitely.

Test Plan (N=4, WIDTH=32):
- Reset release, then 32 beats with in_data=1..32 and in_last on beat 32 -> matrix_A[k]=k+1, matrix_B[k]=k+17; start high exactly one cycle, the cycle after beat 32; busy=1; in_ready=0.
- In WAIT, drive result_ready high for 3 cycles -> frame_count=1 (not 3); in_ready=1 the next cycle; a second 32-beat frame gives frame_count=2 after its result_ready.
- in_valid toggled randomly, 50% duty, over a frame -> same arrays as the unstalled case; exactly one start.
- in_last on beat 10 -> proto_err pulse; no start; next 32 beats form a clean frame with data from beat 11 onward; final beat without in_last -> proto_err, start still issued.
- Assert rst during WAIT and again mid LOAD_B -> all arrays 0, frame_count=0, no start, in_ready=1 after release.
- PIM_LOADER_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, result_ready never asserted -> timeout pulses 16 cycles after WAIT entry; back in LOAD_A; frame_count unchanged.
